// File: rtl/aes_stream_loader_if.sv
// ----------------------------------------------------------------------------
// aes_stream_loader_if
//   Word-stream bundle for the AES stream loader: a 32-bit valid/ready input
//   stream carrying key/data words plus per-transaction mode bits, and a
//   32-bit valid/ready output stream carrying result words.
//
//   Signals
//     in_valid, in_data[31:0], in_mode, in_key_sel : upstream -> loader
//     in_ready                                     : loader -> upstream
//     out_valid, out_data[31:0], out_last          : loader -> downstream
//     out_ready                                    : downstream -> loader
//
//   Modports
//     master : the stream environment (word source and result sink)
//     slave  : the loader itself
// ----------------------------------------------------------------------------
interface aes_stream_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_mode;
  logic        in_key_sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output in_valid, in_data, in_mode, in_key_sel, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_key_sel, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/aes_stream_loader.sv
// ----------------------------------------------------------------------------
// aes_stream_loader
//   Collects eight big-endian 32-bit words (4 key + 4 data) into 128-bit
//   key/data registers, pulses the encrypt or decrypt start line, waits for
//   the matching done (bounded by WAIT_TIMEOUT cycles), then streams the
//   128-bit result back as four 32-bit words.
//
//   Parameter
//     WAIT_TIMEOUT : cycles allowed in WAIT before abort (2..1023)
//
//   Ports
//     clk, reset                : clock, asynchronous active-low reset
//     bus (slave)               : input/output word streams
//     aes_key, aes_data         : assembled key and block to the core
//     aes_start_enc/dec         : one-cycle start pulses
//     aes_done_enc/dec          : core done lines
//     aes_cipher, aes_decrypted : core results
//     busy                      : high whenever not idle
//     err                       : one-cycle pulse on timeout abort
//
//   Optional feature macro: AES_KEY_HOLD_EN
//     When defined, in_key_sel = 0 on the first word skips the key load and
//     reuses the stored key (4 data words only).
// ----------------------------------------------------------------------------
module aes_stream_loader #(
  parameter int unsigned WAIT_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  aes_stream_loader_if.slave bus,
  output logic [127:0]       aes_key,
  output logic [127:0]       aes_data,
  output logic               aes_start_enc,
  output logic               aes_start_dec,
  input  logic               aes_done_enc,
  input  logic               aes_done_dec,
  input  logic [127:0]       aes_cipher,
  input  logic [127:0]       aes_decrypted,
  output logic               busy,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_KEY  = 3'd1,
    S_LOAD_DATA = 3'd2,
    S_START     = 3'd3,
    S_WAIT      = 3'd4,
    S_DRAIN     = 3'd5
  } state_t;

  localparam logic [9:0] TIMEOUT_C = 10'(WAIT_TIMEOUT);

  state_t        state_r, state_n;
  logic [1:0]    idx_r, idx_n;
  logic          mode_r, mode_n;
  logic [127:0]  key_r, key_n;
  logic [127:0]  data_r, data_n;
  logic [127:0]  res_r, res_n;
  logic [9:0]    cnt_r, cnt_n;
  logic          err_n;

  logic          in_ready_r, out_valid_r, out_last_r, busy_r, err_r;
  logic          start_enc_r, start_dec_r;
  logic [31:0]   out_data_r;

  logic          accept_s, drain_hs_s, done_s;
  logic [127:0]  result_s;

  // Big-endian word read: index 0 is bits [127:96].
  function automatic logic [31:0] word_get(input logic [127:0] blk, input logic [1:0] idx);
    case (idx)
      2'd0:    word_get = blk[127:96];
      2'd1:    word_get = blk[95:64];
      2'd2:    word_get = blk[63:32];
      2'd3:    word_get = blk[31:0];
      default: word_get = 32'd0;
    endcase
  endfunction

  // Big-endian word write: returns blk with word idx replaced by w.
  function automatic logic [127:0] word_put(input logic [127:0] blk, input logic [1:0] idx,
                                            input logic [31:0] w);
    word_put = blk;
    case (idx)
      2'd0:    word_put[127:96] = w;
      2'd1:    word_put[95:64]  = w;
      2'd2:    word_put[63:32]  = w;
      2'd3:    word_put[31:0]   = w;
      default: word_put = blk;
    endcase
  endfunction

  // Handshakes use the registered ready/valid so they match what the peers see.
  assign accept_s   = in_ready_r & bus.in_valid;
  assign drain_hs_s = out_valid_r & bus.out_ready;
  // Only the done/result of the latched mode matters; the other core is ignored.
  assign done_s     = mode_r ? aes_done_dec : aes_done_enc;
  assign result_s   = mode_r ? aes_decrypted : aes_cipher;

`ifndef AES_KEY_HOLD_EN
  logic unused_key_sel_s;
  assign unused_key_sel_s = bus.in_key_sel;
`endif

  // Next-state and datapath update logic.
  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    mode_n  = mode_r;
    key_n   = key_r;
    data_n  = data_r;
    res_n   = res_r;
    cnt_n   = cnt_r;
    err_n   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          mode_n = bus.in_mode;
          idx_n  = 2'd1;
`ifdef AES_KEY_HOLD_EN
          if (bus.in_key_sel) begin
            key_n   = word_put(key_r, 2'd0, bus.in_data);
            state_n = S_LOAD_KEY;
          end else begin
            data_n  = word_put(data_r, 2'd0, bus.in_data);
            state_n = S_LOAD_DATA;
          end
`else
          key_n   = word_put(key_r, 2'd0, bus.in_data);
          state_n = S_LOAD_KEY;
`endif
        end else begin
          state_n = S_IDLE;
        end
      end
      S_LOAD_KEY: begin
        if (accept_s) begin
          key_n = word_put(key_r, idx_r, bus.in_data);
          idx_n = idx_r + 2'd1;  // wraps to 0 for the data phase
          if (idx_r == 2'd3) begin
            state_n = S_LOAD_DATA;
          end else begin
            state_n = S_LOAD_KEY;
          end
        end else begin
          state_n = S_LOAD_KEY;
        end
      end
      S_LOAD_DATA: begin
        if (accept_s) begin
          data_n = word_put(data_r, idx_r, bus.in_data);
          idx_n  = idx_r + 2'd1;
          if (idx_r == 2'd3) begin
            state_n = S_START;
          end else begin
            state_n = S_LOAD_DATA;
          end
        end else begin
          state_n = S_LOAD_DATA;
        end
      end
      S_START: begin
        // Done is not looked at here, so a stale level from a previous run is ignored.
        cnt_n   = 10'd0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (done_s) begin
          res_n   = result_s;
          idx_n   = 2'd0;
          state_n = S_DRAIN;
        end else begin
          cnt_n = cnt_r + 10'd1;
          if (cnt_n == TIMEOUT_C) begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_DRAIN: begin
        if (drain_hs_s) begin
          idx_n = idx_r + 2'd1;
          if (idx_r == 2'd3) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_DRAIN;
          end
        end else begin
          state_n = S_DRAIN;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; outputs are decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      idx_r       <= 2'd0;
      mode_r      <= 1'b0;
      key_r       <= 128'd0;
      data_r      <= 128'd0;
      res_r       <= 128'd0;
      cnt_r       <= 10'd0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= 32'd0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      start_enc_r <= 1'b0;
      start_dec_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      idx_r       <= idx_n;
      mode_r      <= mode_n;
      key_r       <= key_n;
      data_r      <= data_n;
      res_r       <= res_n;
      cnt_r       <= cnt_n;
      in_ready_r  <= (state_n == S_IDLE) || (state_n == S_LOAD_KEY) || (state_n == S_LOAD_DATA);
      out_valid_r <= (state_n == S_DRAIN);
      out_last_r  <= (state_n == S_DRAIN) && (idx_n == 2'd3);
      out_data_r  <= (state_n == S_DRAIN) ? word_get(res_n, idx_n) : 32'd0;
      busy_r      <= (state_n != S_IDLE);
      err_r       <= err_n;
      start_enc_r <= (state_n == S_START) && !mode_n;
      start_dec_r <= (state_n == S_START) && mode_n;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;
  assign aes_key       = key_r;
  assign aes_data      = data_r;
  assign aes_start_enc = start_enc_r;
  assign aes_start_dec = start_dec_r;
  assign busy          = busy_r;
  assign err           = err_r;

endmodule

// File: tb/tb_aes_stream_loader.sv
// ----------------------------------------------------------------------------
// tb_aes_stream_loader
//   Self-checking bench for aes_stream_loader. A stand-in AES core answers
//   start pulses after a random latency (FIPS-197 vectors by lookup, other
//   blocks by a simple reversible mix). Expected result words come from the
//   words the bench sent, never from the loader's registers. Build with
//   +define+AES_KEY_HOLD_EN to exercise the key-hold feature.
// ----------------------------------------------------------------------------
module tb_aes_stream_loader;

  localparam int unsigned TMO = 8;
`ifdef AES_KEY_HOLD_EN
  localparam bit KH = 1'b1;
`else
  localparam bit KH = 1'b0;
`endif

  localparam logic [127:0] FK  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FPT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FCT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] aes_key, aes_data, aes_cipher, aes_decrypted;
  logic         aes_start_enc, aes_start_dec, aes_done_enc, aes_done_dec;
  logic         busy, err;

  always #5 clk = ~clk;

  aes_stream_loader_if bus();

  aes_stream_loader #(.WAIT_TIMEOUT(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .aes_key       (aes_key),
    .aes_data      (aes_data),
    .aes_start_enc (aes_start_enc),
    .aes_start_dec (aes_start_dec),
    .aes_done_enc  (aes_done_enc),
    .aes_done_dec  (aes_done_dec),
    .aes_cipher    (aes_cipher),
    .aes_decrypted (aes_decrypted),
    .busy          (busy),
    .err           (err)
  );

  // ---------------- stand-in AES core ----------------
  function automatic logic [127:0] core_enc(input logic [127:0] k, input logic [127:0] d);
    if (k == FK && d == FPT) return FCT;
    return k ^ {d[63:0], d[127:64]};
  endfunction

  function automatic logic [127:0] core_dec(input logic [127:0] k, input logic [127:0] d);
    if (k == FK && d == FCT) return FPT;
    return k ^ ~d;
  endfunction

  logic core_en = 1'b1, core_dec_mode, core_done_enc_r, core_done_dec_r;
  logic cur_mode = 1'b0, force_done_enc = 1'b0, noise_r = 1'b0;
  int   core_cnt, core_lat = 3;
  int   st_enc_tot = 0, st_dec_tot = 0;

  assign aes_cipher    = core_enc(aes_key, aes_data);
  assign aes_decrypted = core_dec(aes_key, aes_data);
  // Random noise only ever appears on the done line of the unused core.
  assign aes_done_enc  = core_done_enc_r | force_done_enc | (cur_mode & noise_r);
  assign aes_done_dec  = core_done_dec_r | (~cur_mode & noise_r);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_cnt <= 0; core_done_enc_r <= 1'b0; core_done_dec_r <= 1'b0; core_dec_mode <= 1'b0;
    end else begin
      core_done_enc_r <= 1'b0;
      core_done_dec_r <= 1'b0;
      if (core_cnt > 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1) begin
          if (core_dec_mode) core_done_dec_r <= 1'b1;
          else               core_done_enc_r <= 1'b1;
        end
      end else if (core_en && (aes_start_enc || aes_start_dec)) begin
        core_cnt      <= core_lat;
        core_dec_mode <= aes_start_dec;
      end
    end
  end

  always @(negedge clk) begin
    noise_r = 1'($urandom_range(0, 1));
    if (aes_start_enc) st_enc_tot = st_enc_tot + 1;
    if (aes_start_dec) st_dec_tot = st_dec_tot + 1;
  end

  // ---------------- checking helpers ----------------
  int checks = 0, errors = 0;
  logic [127:0] model_key = 128'd0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"},  128'(bus.in_ready), 128'd0);
    chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'd0);
    chk({tag, "_out_data"},  128'(bus.out_data), 128'd0);
    chk({tag, "_out_last"},  128'(bus.out_last), 128'd0);
    chk({tag, "_aes_key"},   aes_key, 128'd0);
    chk({tag, "_aes_data"},  aes_data, 128'd0);
    chk({tag, "_start_enc"}, 128'(aes_start_enc), 128'd0);
    chk({tag, "_start_dec"}, 128'(aes_start_dec), 128'd0);
    chk({tag, "_busy"},      128'(busy), 128'd0);
    chk({tag, "_err"},       128'(err), 128'd0);
  endtask

  // Called and returns at a falling edge; the word is taken at the rising edge in between.
  task automatic send_word(input logic [31:0] w, input logic mode, input logic ksel);
    int n;
    n = 0;
    bus.in_valid = 1'b1; bus.in_data = w; bus.in_mode = mode; bus.in_key_sel = ksel;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("in_ready_wait", 128'(bus.in_ready), 128'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
  endtask

  // Loads one transaction; only the first word carries the real mode/key_sel.
  task automatic load_txn(input logic [127:0] key, input logic [127:0] data,
                          input logic mode, input logic ksel);
    logic [31:0] words [8];
    int nw, first;
    cur_mode = mode;
    nw = (KH && !ksel) ? 4 : 8;
    first = 8 - nw;
    for (int i = 0; i < 4; i++) begin
      words[i]     = key[(3 - i) * 32 +: 32];
      words[i + 4] = data[(3 - i) * 32 +: 32];
    end
    for (int i = first; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_word(words[i], (i == first) ? mode : ~mode, (i == first) ? ksel : ~ksel);
    end
    // Cycle after the last accept: START, loader no longer ready.
    chk("in_ready_after_load", 128'(bus.in_ready), 128'd0);
    chk("start_enc_level", 128'(aes_start_enc), 128'(!mode));
    chk("start_dec_level", 128'(aes_start_dec), 128'(mode));
    if (nw == 8) model_key = key;
  endtask

  task automatic run_txn(input logic [127:0] key, input logic [127:0] data, input logic mode,
                         input logic ksel, input logic [127:0] exp, input bit bp, input int abort_at);
    int n, e0, d0, hold;
    logic [31:0] ew;
    e0 = st_enc_tot; d0 = st_dec_tot;
    core_lat = $urandom_range(1, 5);
    load_txn(key, data, mode, ksel);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("out_valid_wait", 128'(bus.out_valid), 128'd1);
    for (int w = 0; w < 4; w++) begin
      ew = exp[(3 - w) * 32 +: 32];
      if (w == abort_at) begin
        reset = 1'b0;
        #1;
        check_zero("rst_drain");
        @(negedge clk);
        reset = 1'b1;
        model_key = 128'd0;
        return;
      end
      hold = bp ? 5 : $urandom_range(0, 2);
      repeat (hold) begin
        @(negedge clk);
        chk("hold_data", 128'(bus.out_data), 128'(ew));
        chk("hold_valid", 128'(bus.out_valid), 128'd1);
      end
      bus.out_ready = 1'b1;
      chk("out_data", 128'(bus.out_data), 128'(ew));
      chk("out_last", 128'(bus.out_last), 128'(w == 3));
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
    chk("valid_after_drain", 128'(bus.out_valid), 128'd0);
    chk("ready_after_drain", 128'(bus.in_ready), 128'd1);
    chk("busy_after_drain", 128'(busy), 128'd0);
    chk("enc_pulses", 128'(st_enc_tot - e0), 128'(mode ? 0 : 1));
    chk("dec_pulses", 128'(st_dec_tot - d0), 128'(mode ? 1 : 0));
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] data;
    logic         mode;
    bit           bp;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k, d, kuse, ex;
    logic m, ks;

    bus.in_valid = 1'b0; bus.in_data = 32'd0; bus.in_mode = 1'b0;
    bus.in_key_sel = 1'b1; bus.out_ready = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    chk("ready_before_edge", 128'(bus.in_ready), 128'd0);
    @(negedge clk);
    chk("ready_after_reset", 128'(bus.in_ready), 128'd1);
    chk("busy_after_reset", 128'(busy), 128'd0);

    vecs[0] = '{FK, FPT, 1'b0, 1'b0, FCT};
    vecs[1] = '{FK, FCT, 1'b1, 1'b0, FPT};
    vecs[2] = '{FK, FPT, 1'b0, 1'b1, FCT};
    vecs[3] = '{{4{32'hffff_0000}}, 128'h0123456789abcdef_fedcba9876543210, 1'b0, 1'b0,
                core_enc({4{32'hffff_0000}}, 128'h0123456789abcdef_fedcba9876543210)};
    vecs[4] = '{128'hdeadbeef_0badf00d_12345678_9abcdef0, {4{32'h5a5a_a5a5}}, 1'b1, 1'b1,
                core_dec(128'hdeadbeef_0badf00d_12345678_9abcdef0, {4{32'h5a5a_a5a5}})};
    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].key, vecs[i].data, vecs[i].mode, 1'b1, vecs[i].exp, vecs[i].bp, 4);
    end

    // Timeout: no core answer; a stale done during START must be ignored.
    core_en = 1'b0;
    load_txn(FK, FPT, 1'b0, 1'b1);
    force_done_enc = 1'b1;
    for (int kk = 1; kk <= int'(TMO) + 3; kk++) begin
      @(negedge clk);
      force_done_enc = 1'b0;
      chk("tmo_err", 128'(err), 128'(kk == int'(TMO) + 1));
      chk("tmo_out_valid", 128'(bus.out_valid), 128'd0);
      if (kk == int'(TMO) + 1) chk("tmo_ready", 128'(bus.in_ready), 128'd1);
    end
    core_en = 1'b1;

    // Reset after five input words.
    cur_mode = 1'b0;
    for (int i = 0; i < 5; i++) send_word(32'h1000_0000 + 32'(i), 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    check_zero("rst_load");
    @(negedge clk);
    reset = 1'b1;
    model_key = 128'd0;
    chk("rst_load_ready0", 128'(bus.in_ready), 128'd0);
    @(negedge clk);
    chk("rst_load_ready1", 128'(bus.in_ready), 128'd1);

    // Reset while word 2 is being drained, then a clean transaction.
    run_txn(FK, FPT, 1'b0, 1'b1, FCT, 1'b0, 2);
    @(negedge clk);
    run_txn(FK, FCT, 1'b1, 1'b1, FPT, 1'b0, 4);

`ifdef AES_KEY_HOLD_EN
    run_txn(FK, FPT, 1'b0, 1'b1, FCT, 1'b0, 4);
    run_txn(128'd0, FPT, 1'b0, 1'b0, FCT, 1'b0, 4);
`endif

    // Randomised transactions against the bench model.
    for (int t = 0; t < 16; t++) begin
      k  = {$urandom, $urandom, $urandom, $urandom};
      d  = {$urandom, $urandom, $urandom, $urandom};
      m  = 1'($urandom_range(0, 1));
      ks = 1'($urandom_range(0, 1));
      kuse = (KH && !ks) ? model_key : k;
      ex = m ? core_dec(kuse, d) : core_enc(kuse, d);
      run_txn(k, d, m, ks, ex, 1'($urandom_range(0, 1)), 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_stream_loader.md
# aes_stream_loader

Upstream/downstream stream adapter for the AES top (`AES` with encryption and decryption cores). It collects 32-bit words from a valid/ready input stream into a 128-bit key and a 128-bit data block. It then pulses the matching start line and waits for the core's done. Finally it returns the 128-bit result as four 32-bit words on a valid/ready output stream.

## Interface
Parameters:
- WAIT_TIMEOUT, 64: maximum number of cycles spent in WAIT before the transaction is aborted; range 2..1023.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; 0 = reset
- in_valid  input  1  input word valid
- in_ready  output  1  loader can accept a word
- in_data  input  32  input word
- in_mode  input  1  0 = encrypt, 1 = decrypt; sampled on the first accepted word of a transaction
- in_key_sel  input  1  1 = this transaction carries a key; used only with AES_KEY_HOLD_EN
- aes_key  output  128  key to core
- aes_data  output  128  block to core
- aes_start_enc  output  1  one-cycle start pulse, encrypt
- aes_start_dec  output  1  one-cycle start pulse, decrypt
- aes_done_enc  input  1  encryption core done
- aes_done_dec  input  1  decryption core done
- aes_cipher  input  128  encryption result
- aes_decrypted  input  128  decryption result
- out_valid  output  1  output word valid
- out_ready  input  1  sink accepts word
- out_data  output  32  output word
- out_last  output  1  high with the 4th output word
- busy  output  1  high in every state except IDLE
- err  output  1  one-cycle pulse on timeout abort

## Operation
- FSM states: IDLE, LOAD_KEY, LOAD_DATA, START, WAIT, DRAIN. A 2-bit word index counts words in each load and drain phase.
- Word order is big-endian: word 0 = bits [127:96] and word 3 = bits [31:0]. This applies to input and output.
- A word is accepted on `in_valid & in_ready`. `in_ready` is 1 only in IDLE, LOAD_KEY and LOAD_DATA.
- IDLE, first word accepted:
  - Latch `in_mode`.
  - The word becomes key word 0.
  - Go to LOAD_KEY with index = 1.
- LOAD_KEY: after key word 3 is accepted, go to LOAD_DATA with index = 0.
- LOAD_DATA: after data word 3 is accepted, go to START.
- START (exactly one cycle):
  - Assert `aes_start_enc` or `aes_start_dec` per the latched mode. The other start line stays 0.
  - Reset the timeout counter.
  - Go to WAIT.
- WAIT:
  - Monitor only the done line for the latched mode; the other done line is ignored.
  - On done = 1: capture the matching result (`aes_cipher` or `aes_decrypted`) into the output register and go to DRAIN with index = 0.
  - Otherwise increment the counter. When the counter reaches WAIT_TIMEOUT, pulse `err` for one cycle and go to IDLE. No output is produced.
- DRAIN:
  - `out_valid` = 1 and `out_data` = captured word[index].
  - `out_last` = 1 when index = 3.
  - index advances on `out_valid & out_ready`.
  - After the handshake on word 3, go to IDLE.
- `aes_key` and `aes_data` change only when a word is accepted. They are stable from START until the next transaction's first word.
- `in_valid` held low mid-load stalls the load indefinitely; no timeout applies in the load states.

## Timing
- Reset (reset = 0) is asynchronous. All outputs return to 0, state = IDLE, and the key, data, result registers and index are cleared. This applies in any state, including mid-load, WAIT and DRAIN.
- `in_ready` goes high on the first rising edge after reset deasserts.
- With the last input word accepted at edge N:
  - START is active in cycle N+1.
  - WAIT begins at N+2. Done is sampled no earlier than N+2, so a stale done level present during START is ignored.
- Done observed at edge M: `out_valid` rises in cycle M+1.
- Output throughput is 1 word per cycle when `out_ready` is held high. `out_valid` and `out_data` are held steady while `out_ready` = 0.
- Input throughput is 1 word per cycle, giving 8 cycles minimum per full load.
- There is no overlap: the next transaction's first word is accepted at the earliest in the cycle after the final DRAIN handshake.
- The timeout abort occurs WAIT_TIMEOUT cycles after WAIT entry. `err` is high in the cycle the FSM returns to IDLE.

## Configuration
- AES_KEY_HOLD_EN defined:
  - `in_key_sel` is sampled with the first word.
  - If 1: the normal 8-word sequence runs and the key register is updated.
  - If 0: the first word is data word 0, LOAD_KEY is skipped, and the previously stored key is reused. The stored key after reset is all zeros.
- AES_KEY_HOLD_EN undefined: `in_key_sel` is ignored and every transaction is 4 key words followed by 4 data words.

## Test plan
- Encrypt test (FIPS-197):
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff, in_mode = 0.
  - Required: `aes_start_enc` is a single pulse and `aes_start_dec` stays 0.
  - Required output words: 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a, with `out_last` on the 4th.
- Decrypt test: same key, data 69c4e0d86a7b0430d8cdb78070b4c55a, in_mode = 1 -> output 00112233, 44556677, 8899aabb, ccddeeff.
- Backpressure test: hold `out_ready` = 0 for 5 cycles per word during DRAIN -> `out_data` is stable and no word is lost or duplicated.
- Timeout test: drive done lines tied 0 with WAIT_TIMEOUT = 8 -> `err` pulses exactly 8 cycles after WAIT entry, `out_valid` is never 1, and `in_ready` is 1 the next cycle.
- Reset mid-operation: assert reset after 5 input words and again during DRAIN word 2 -> all outputs read 0 immediately. The next full transaction then produces correct results.
- Key hold (AES_KEY_HOLD_EN):
  - Stimulus: run the encrypt vector, then a second transaction with in_key_sel = 0 and 4 data words 00112233445566778899aabbccddeeff.
  - Required: `in_ready` drops after 4 words and the output is again 69c4e0d8….
